// File: rtl/cppf_hit_aligner.sv
// CPPF hit aligner: unpacks six hit slots per BX, filters frames, realigns hits by bx_ago via a BX ring; no backpressure.
// Latency 1+LAT-bx_ago cycles from input sampling; optional CRC filtering under CPPF_CRC_CHECK_EN.
module cppf_hit_aligner #(
    parameter int DEPTH_LOG2 = 3,
    parameter int LAT        = 4
) (
    input  logic              clk_40,
    input  logic              reset_n,
    input  logic [2:0][63:0]  rxdata_in,
    input  logic              rx_valid,
    input  logic [7:0]        link_id,
    input  logic              crc_match,
    input  logic [7:0]        link_id_exp,
    input  logic              cnt_clr,
    output logic [5:0][27:0]  hit_o,
    output logic [5:0]        hit_vld_o,
    output logic [15:0]       err_crc_cnt,
    output logic [15:0]       err_link_cnt,
    output logic [15:0]       err_late_cnt,
    output logic [15:0]       err_coll_cnt
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] LAT_U = LAT;

    if (LAT < 1 || LAT > DEPTH - 1) begin : g_bad_lat
        $error("cppf_hit_aligner: LAT must be within 1..2**DEPTH_LOG2-1");
    end

    logic [2:0][63:0]              r_rxdata;
    logic                          r_rx_valid;
    logic [7:0]                    r_link_id;
    logic                          r_crc_match;
    logic                          r_cnt_clr;
    logic [DEPTH_LOG2-1:0]         r_wr_ptr;
    logic [DEPTH-1:0][5:0]         r_ring_vld;
    logic [DEPTH-1:0][5:0][27:0]   r_ring_dat;

    logic [5:0][31:0]              w_slot;
    logic [5:0][DEPTH_LOG2-1:0]    w_tgt;
    logic [5:0]                    w_wr;
    logic [5:0]                    w_late;
    logic [5:0]                    w_coll;
    logic [2:0]                    w_late_n;
    logic [2:0]                    w_coll_n;
    logic [DEPTH_LOG2-1:0]         w_rd_ptr;
    logic                          w_crc_ok;
    logic                          w_link_err;
    logic                          w_frame_ok;

    function automatic logic [15:0] f_sat(input logic [15:0] c, input logic [2:0] n);
        logic [16:0] s;
        s = {1'b0, c} + {14'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            r_rxdata    <= '0;
            r_rx_valid  <= 1'b0;
            r_link_id   <= '0;
            r_crc_match <= 1'b0;
            r_cnt_clr   <= 1'b0;
        end else begin
            r_rxdata    <= rxdata_in;
            r_rx_valid  <= rx_valid;
            r_link_id   <= link_id;
            r_crc_match <= crc_match;
            r_cnt_clr   <= cnt_clr;
        end
    end

`ifdef CPPF_CRC_CHECK_EN
    assign w_crc_ok = r_crc_match;
`else
    logic w_unused_crc;
    assign w_crc_ok     = 1'b1;
    assign w_unused_crc = r_crc_match;
`endif
    assign w_link_err = r_rx_valid & w_crc_ok & (r_link_id != link_id_exp);
    assign w_frame_ok = r_rx_valid & w_crc_ok & (r_link_id == link_id_exp);
    assign w_rd_ptr   = r_wr_ptr - DEPTH_LOG2'(LAT);

    // Same-frame slots own distinct positions, so collisions are only against stored hits.
    always_comb begin
        w_late_n = '0;
        w_coll_n = '0;
        for (int k = 0; k < 6; k++) begin
            w_slot[k] = r_rxdata[k / 2][(k % 2) * 32 +: 32];
            w_tgt[k]  = r_wr_ptr - DEPTH_LOG2'(w_slot[k][30:28]);
            w_late[k] = w_frame_ok & w_slot[k][31] & ({29'd0, w_slot[k][30:28]} >= LAT_U);
            w_wr[k]   = w_frame_ok & w_slot[k][31] & ({29'd0, w_slot[k][30:28]} <  LAT_U);
            w_coll[k] = w_wr[k] & r_ring_vld[w_tgt[k]][k];
            w_late_n  = w_late_n + {2'd0, w_late[k]};
            w_coll_n  = w_coll_n + {2'd0, w_coll[k]};
        end
    end

    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_ring_vld <= '0;
            r_ring_dat <= '0;
            hit_o      <= '0;
            hit_vld_o  <= '0;
        end else begin
            r_wr_ptr             <= r_wr_ptr + 1'b1;
            hit_o                <= r_ring_dat[w_rd_ptr];
            hit_vld_o            <= r_ring_vld[w_rd_ptr];
            r_ring_vld[w_rd_ptr] <= '0;
            r_ring_dat[w_rd_ptr] <= '0;
            for (int k = 0; k < 6; k++) begin
                if (w_wr[k] && !w_coll[k]) begin
                    r_ring_vld[w_tgt[k]][k] <= 1'b1;
                    r_ring_dat[w_tgt[k]][k] <= w_slot[k][27:0];
                end
            end
        end
    end

    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            err_link_cnt <= '0;
            err_late_cnt <= '0;
            err_coll_cnt <= '0;
        end else if (r_cnt_clr) begin
            err_link_cnt <= '0;
            err_late_cnt <= '0;
            err_coll_cnt <= '0;
        end else begin
            err_link_cnt <= f_sat(err_link_cnt, {2'd0, w_link_err});
            err_late_cnt <= f_sat(err_late_cnt, w_late_n);
            err_coll_cnt <= f_sat(err_coll_cnt, w_coll_n);
        end
    end

`ifdef CPPF_CRC_CHECK_EN
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            err_crc_cnt <= '0;
        end else if (r_cnt_clr) begin
            err_crc_cnt <= '0;
        end else begin
            err_crc_cnt <= f_sat(err_crc_cnt, {2'd0, r_rx_valid & ~r_crc_match});
        end
    end
`else
    assign err_crc_cnt = '0;
`endif

endmodule

// File: tb/tb_cppf_hit_aligner.sv
// Bench for cppf_hit_aligner: a BX-timeline model predicts each output cycle and counter value.
module tb_cppf_hit_aligner;
    localparam int LAT = 4;
    localparam int W   = 64;
`ifdef CPPF_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic             clk_40 = 1'b0;
    logic             reset_n;
    logic [2:0][63:0] rxdata_in;
    logic             rx_valid;
    logic [7:0]       link_id;
    logic             crc_match;
    logic [7:0]       link_id_exp;
    logic             cnt_clr;
    logic [5:0][27:0] hit_o;
    logic [5:0]       hit_vld_o;
    logic [15:0]      err_crc_cnt, err_link_cnt, err_late_cnt, err_coll_cnt;

    cppf_hit_aligner #(.DEPTH_LOG2(3), .LAT(LAT)) dut (
        .clk_40(clk_40), .reset_n(reset_n), .rxdata_in(rxdata_in), .rx_valid(rx_valid),
        .link_id(link_id), .crc_match(crc_match), .link_id_exp(link_id_exp), .cnt_clr(cnt_clr),
        .hit_o(hit_o), .hit_vld_o(hit_vld_o), .err_crc_cnt(err_crc_cnt),
        .err_link_cnt(err_link_cnt), .err_late_cnt(err_late_cnt), .err_coll_cnt(err_coll_cnt)
    );

    always #5 clk_40 = ~clk_40;

    int cyc = 0;
    always @(posedge clk_40) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Model: expected outputs indexed by the edge after which they must be visible.
    logic [5:0]       m_vld [W];
    logic [5:0][27:0] m_dat [W];
    int               p_crc [W], p_link [W], p_late [W], p_coll [W];
    bit               p_clr [W];
    int               m_crc, m_link, m_late, m_coll;
    logic [31:0]      s [6];
    int               idx;

    task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int c, input int n);
        return (c + n > 65535) ? 65535 : c + n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < W; i++) begin
            m_vld[i] = '0; m_dat[i] = '0;
            p_crc[i] = 0; p_link[i] = 0; p_late[i] = 0; p_coll[i] = 0; p_clr[i] = 1'b0;
        end
        m_crc = 0; m_link = 0; m_late = 0; m_coll = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_40);
        #1;
    endtask

    // Presents s[] for one BX starting just after edge e; sampled at edge e+1.
    task automatic drive(input logic v, input logic [7:0] id, input logic crc, input logic clr);
        int e, tc, te;
        int b;
        e  = cyc;
        tc = (e + 2) % W;
        for (int k = 0; k < 6; k++) rxdata_in[k / 2][(k % 2) * 32 +: 32] = s[k];
        rx_valid = v; link_id = id; crc_match = crc; cnt_clr = clr;
        if (clr) p_clr[tc] = 1'b1;
        if (v) begin
            if (CRC_EN && !crc) p_crc[tc]++;
            else if (id != link_id_exp) p_link[tc]++;
            else begin
                for (int k = 0; k < 6; k++) begin
                    if (s[k][31]) begin
                        b = int'(s[k][30:28]);
                        if (b >= LAT) p_late[tc]++;
                        else begin
                            te = (e + 2 + LAT - b) % W;
                            if (m_vld[te][k]) p_coll[tc]++;
                            else begin
                                m_vld[te][k] = 1'b1;
                                m_dat[te][k] = s[k][27:0];
                            end
                        end
                    end
                end
            end
        end
        @(posedge clk_40);
        #1;
        rx_valid = 1'b0; cnt_clr = 1'b0; crc_match = 1'b1; link_id = link_id_exp; rxdata_in = '0;
        for (int k = 0; k < 6; k++) s[k] = '0;
    endtask

    always @(negedge clk_40) begin
        if (chk_en) begin
            idx = cyc % W;
            if (p_clr[idx]) begin
                m_crc = 0; m_link = 0; m_late = 0; m_coll = 0;
            end else begin
                m_crc  = sat(m_crc,  p_crc[idx]);
                m_link = sat(m_link, p_link[idx]);
                m_late = sat(m_late, p_late[idx]);
                m_coll = sat(m_coll, p_coll[idx]);
            end
            p_crc[idx] = 0; p_link[idx] = 0; p_late[idx] = 0; p_coll[idx] = 0; p_clr[idx] = 1'b0;
            check("hit_vld", {162'd0, hit_vld_o}, {162'd0, m_vld[idx]});
            check("hit_dat", hit_o, m_dat[idx]);
            check("crc_cnt",  {152'd0, err_crc_cnt},  168'(m_crc));
            check("link_cnt", {152'd0, err_link_cnt}, 168'(m_link));
            check("late_cnt", {152'd0, err_late_cnt}, 168'(m_late));
            check("coll_cnt", {152'd0, err_coll_cnt}, 168'(m_coll));
            m_vld[idx] = '0;
            m_dat[idx] = '0;
        end
    end

    initial begin
        reset_n = 1'b1; rx_valid = 1'b0; rxdata_in = '0; link_id = 8'h13; link_id_exp = 8'h13;
        crc_match = 1'b1; cnt_clr = 1'b0;
        for (int k = 0; k < 6; k++) s[k] = '0;
        model_clear();
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_vld",  {162'd0, hit_vld_o}, 168'd0);
        check("rst_dat",  hit_o, 168'd0);
        check("rst_late", {152'd0, err_late_cnt}, 168'd0);
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(3);

        // Aligned hit, b=0: visible 5 edges after sampling, then gone.
        s[2] = {1'b1, 3'd0, 28'hABCDEF1};
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        wait_cyc(5);
        check("aligned_vld", {162'd0, hit_vld_o}, {162'd0, 6'b000100});
        check("aligned_dat", {140'd0, hit_o[2]}, {140'd0, 28'hABCDEF1});
        wait_cyc(1);
        check("aligned_gone", {162'd0, hit_vld_o}, 168'd0);
        check("aligned_gone_dat", {140'd0, hit_o[2]}, 168'd0);

        // b=3: visible 2 edges after sampling.
        s[2] = {1'b1, 3'd3, 28'hABCDEF1};
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        wait_cyc(2);
        check("delayed_vld", {162'd0, hit_vld_o}, {162'd0, 6'b000100});
        check("delayed_dat", {140'd0, hit_o[2]}, {140'd0, 28'hABCDEF1});
        wait_cyc(3);

        // Collision: b=0 then b=1 next BX in slot 0, first one kept.
        s[0] = {1'b1, 3'd0, 28'h1111111};
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        s[0] = {1'b1, 3'd1, 28'h2222222};
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        wait_cyc(4);
        check("coll_kept", {140'd0, hit_o[0]}, {140'd0, 28'h1111111});
        check("coll_cnt1", {152'd0, err_coll_cnt}, 168'd1);
        wait_cyc(2);

        // Late hits: b=4 then b=7 in all six slots.
        for (int k = 0; k < 6; k++) s[k] = {1'b1, 3'd4, 28'(k + 1)};
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        wait_cyc(1);
        check("late_6", {152'd0, err_late_cnt}, 168'd6);
        for (int k = 0; k < 6; k++) s[k] = {1'b1, 3'd7, 28'(k + 9)};
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        wait_cyc(1);
        check("late_12", {152'd0, err_late_cnt}, 168'd12);
        wait_cyc(6);

        // CRC failure frame.
        s[1] = {1'b1, 3'd0, 28'h0C0FFEE};
        drive(1'b1, 8'h13, 1'b0, 1'b0);
`ifdef CPPF_CRC_CHECK_EN
        wait_cyc(1);
        check("crc_cnt1", {152'd0, err_crc_cnt}, 168'd1);
        wait_cyc(5);
`else
        wait_cyc(5);
        check("crc_ignored_vld", {162'd0, hit_vld_o}, {162'd0, 6'b000010});
        check("crc_ignored_dat", {140'd0, hit_o[1]}, {140'd0, 28'h0C0FFEE});
        wait_cyc(1);
`endif

        // Link-ID mismatch.
        s[3] = {1'b1, 3'd0, 28'h5555555};
        drive(1'b1, 8'h12, 1'b1, 1'b0);
        wait_cyc(1);
        check("link_cnt1", {152'd0, err_link_cnt}, 168'd1);
        wait_cyc(6);

        // Reset two cycles after a b=0 hit: it must never appear.
        s[4] = {1'b1, 3'd0, 28'h7777777};
        drive(1'b1, 8'h13, 1'b1, 1'b0);
        wait_cyc(1);
        reset_n = 1'b0;
        model_clear();
        wait_cyc(2);
        check("midrst_vld",  {162'd0, hit_vld_o}, 168'd0);
        check("midrst_late", {152'd0, err_late_cnt}, 168'd0);
        check("midrst_link", {152'd0, err_link_cnt}, 168'd0);
        reset_n = 1'b1;
        wait_cyc(8);

        // Saturation: 11667 frames x 6 late hits > 65535.
        for (int i = 0; i < 11667; i++) begin
            for (int k = 0; k < 6; k++) s[k] = {1'b1, 3'd5, 28'(i)};
            drive(1'b1, 8'h13, 1'b1, 1'b0);
        end
        wait_cyc(1);
        check("late_sat", {152'd0, err_late_cnt}, 168'hFFFF);
        for (int k = 0; k < 6; k++) s[k] = {1'b1, 3'd6, 28'h1};
        drive(1'b1, 8'h13, 1'b1, 1'b1);
        wait_cyc(1);
        check("late_clr", {152'd0, err_late_cnt}, 168'd0);
        wait_cyc(8);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cppf_hit_aligner.md
# cppf_hit_aligner

Consumes the deframed CPPF link payload (three 64-bit frames per BX plus valid, link ID and CRC-match flags) in the `clk_40` domain. Unpacks six 32-bit hit slots per BX and filters frames by CRC status and expected link ID. Each hit is placed into a BX-indexed ring buffer according to its "BX-ago" tag, so every hit leaves the block at a fixed latency relative to its originating bunch crossing. It sits directly downstream of the CPPF link deframer and feeds the sector-processor primitive conversion.

## Interface
- `DEPTH_LOG2`, 3: log2 of ring depth in BX entries.
- `LAT`, 4: fixed output latency in BX; legal range 1..2^DEPTH_LOG2−1, elaborate-time error otherwise.
- `clk_40` in 1: LHC clock, sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rxdata_in` in 64×[2:0]: deframed frames from the deframer.
- `rx_valid` in 1: frames valid this BX.
- `link_id` in 8: received link ID.
- `crc_match` in 1: CRC status from the deframer.
- `link_id_exp` in 8: expected link ID, quasi-static.
- `cnt_clr` in 1: synchronous clear of all error counters.
- `hit_o` out 28×[5:0]: aligned hit payloads.
- `hit_vld_o` out 6: per-position hit valid.
- `err_crc_cnt`, `err_link_cnt`, `err_late_cnt`, `err_coll_cnt` out 16 each: saturating error counters.

## Operation
- **Slot k (0..5)** = `rxdata_in[k>>1][(k&1)*32 +: 32]`.
  - [31] = vld.
  - [30:28] = `bx_ago` b.
  - [27:0] = payload.
- **Stage 1:** inputs registered unconditionally.
- **Stage 2 frame acceptance** uses the registered values.
  - `rx_valid`=0: nothing happens.
  - Otherwise, with `CPPF_CRC_CHECK_EN` defined, `crc_match`=0 → frame dropped, `err_crc_cnt`+1.
  - Otherwise, `link_id`≠`link_id_exp` → frame dropped, `err_link_cnt`+1.
  - CRC failure takes precedence: only one counter increments per frame.
- **Ring:** 2^DEPTH_LOG2 entries × 6 positions, each position holds {vld, payload}.
- **wr_ptr:** DEPTH_LOG2 bits, increments every cycle, wraps modulo 2^DEPTH_LOG2.
- **Per accepted slot with vld=1:**
  - b ≥ LAT: hit dropped, `err_late_cnt` incremented.
  - Else target entry = (wr_ptr − b) mod depth, position k.
  - Position empty: write.
  - Position occupied: keep the existing hit, drop the new one, `err_coll_cnt` incremented.
- **Read:** every cycle, entry (wr_ptr − LAT) mod depth is loaded into `hit_o`/`hit_vld_o` and cleared in the same edge.
  - The read entry never equals a write target, because b < LAT.
- **Counters:**
  - Increment by the number of events in the cycle (0..6 for late/collision).
  - Saturate at 0xFFFF.
  - `cnt_clr` has priority over increment in the same cycle.

## Timing
- **Latency:** a hit with tag b sampled at edge n is visible on outputs after edge n+1+LAT−b.
  - Example: LAT=4, b=0 → 5 cycles.
- Outputs are registered and change only at the read edge.
- **Reset (async assert)** clears:
  - all ring entries and `wr_ptr`;
  - `hit_o` (0) and `hit_vld_o` (0);
  - all counters (0).
- Hits in flight at reset are lost.
- **Reset deassertion:** first read occurs at the first edge; it yields empty entries until written data reaches the read pointer.
- **wr_ptr wrap:** modulo arithmetic only, no special case.
- **Simultaneous events:**
  - Two slots of the same frame always target different positions.
  - Collisions arise only across frames.

## Configuration
- **`CPPF_CRC_CHECK_EN` defined:** frames with `crc_match`=0 are dropped and counted in `err_crc_cnt`.
- **`CPPF_CRC_CHECK_EN` undefined:**
  - `crc_match` is ignored and all such frames proceed to the link-ID check.
  - `err_crc_cnt` is tied to 0.

## Test plan
- **Aligned hit:** LAT=4, slot 2 = {1, b=0, payload 0xABCDEF1} with valid frame and matching ID → `hit_vld_o`=6'b000100, `hit_o[2]`=0xABCDEF1 exactly 5 cycles later, then 0 the next cycle.
- **Delayed tags:** same payload with b=3 → output after 2 cycles; hits b=0 at BX n and b=1 at BX n+1 in slot 0 → collision: first kept, `err_coll_cnt`=1.
- **Late hits:** all six slots with b=4 or b=7 (LAT=4) → no output, `err_late_cnt`=6 per frame.
- **Frame filtering:**
  - `crc_match`=0 with `CPPF_CRC_CHECK_EN` → no hits, `err_crc_cnt`=1.
  - Macro undefined → hits emitted normally.
  - `link_id`=0x12 vs `link_id_exp`=0x13 → dropped, `err_link_cnt`=1.
- **Reset mid-flight:** `reset_n` low 2 cycles after a b=0 hit → outputs 0, nothing emitted afterwards, counters 0.
- **Saturation and clear:** 70000 late hits → `err_late_cnt`=0xFFFF; `cnt_clr` coinciding with a new late hit → 0.
